// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - product-in / sum-out handshake bundle for mac_accumulator
interface mac_accumulator_if #(
    parameter int ACC_W = 12
);
    logic             clear;
    logic [7:0]       prod;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic             sum_ready;
    logic             ovf;

    // Upstream/downstream side: drives products, abort and result consumption
    modport master (
        output clear, prod, prod_valid, sum_ready,
        input  prod_ready, sum, sum_valid, ovf
    );

    // Accumulator side
    modport slave (
        input  clear, prod, prod_valid, sum_ready,
        output prod_ready, sum, sum_valid, ovf
    );
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums NTERMS products per result; MAC_ACCUMULATOR_SATURATE_EN selects saturate vs wrap
module mac_accumulator #(
    parameter int NTERMS = 8,
    parameter int ACC_W  = 12
) (
    input  logic clk,
    input  logic rst,
    mac_accumulator_if.slave bus
);
    localparam int CNT_W = (NTERMS > 1) ? $clog2(NTERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NTERMS - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   add_full;
    logic             carry;
    logic [ACC_W-1:0] add_res;

    // Running sum plus incoming product, with the carry kept for overflow detection
    assign add_full = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, bus.prod};
    assign carry    = add_full[ACC_W];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    // Once pinned at full scale, further nonzero terms carry again and stay pinned
    assign add_res = carry ? '1 : add_full[ACC_W-1:0];
`else
    assign add_res = add_full[ACC_W-1:0];
`endif

    // Ready depends only on state, never on prod_valid
    assign bus.prod_ready = (state_q == ACCUM);
    assign bus.sum        = sum_q;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.ovf        = ovf_q;

    // State and datapath registers; reset drops any partial or held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next state: accumulate until the final term, then hold the result until consumed
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        ovf_d       = ovf_q;
        case (state_q)
            ACCUM: begin
                if (bus.clear) begin
                    // Abort wins over a concurrent product
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (bus.prod_valid) begin
                    ovf_d = ovf_q | carry;
                    if (cnt_q == LAST_CNT) begin
                        sum_d       = add_res;
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = add_res;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // clear is ignored here so a finished result survives
                if (bus.sum_ready) begin
                    sum_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed and random checks of mac_accumulator against a group-sum model
module tb_mac_accumulator;
    localparam int ACC_W   = 12;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_accumulator_if #(.ACC_W(ACC_W)) i8 ();
    mac_accumulator_if #(.ACC_W(ACC_W)) i32 ();

    mac_accumulator #(.NTERMS(8), .ACC_W(ACC_W)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (i8.slave)
    );
    mac_accumulator #(.NTERMS(32), .ACC_W(ACC_W)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (i32.slave)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Model: which DUT is driven, and the group being collected / result being held
    int sel     = 0;
    int nterms  = 8;
    bit m_hold  = 0;
    bit m_valid = 0;
    bit m_ovf   = 0;
    int m_total = 0;
    int m_cnt   = 0;
    int m_sum   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int group_result(input int total);
        if (SAT) return (total > ACC_MAX) ? ACC_MAX : total;
        return total % (ACC_MAX + 1);
    endfunction

    task automatic read_out(output logic pr, output logic [31:0] sm, output logic sv, output logic ov);
        if (sel == 0) begin
            pr = i8.prod_ready; sm = 32'(i8.sum); sv = i8.sum_valid; ov = i8.ovf;
        end else begin
            pr = i32.prod_ready; sm = 32'(i32.sum); sv = i32.sum_valid; ov = i32.ovf;
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] p, input logic clr, input logic rdy);
        if (sel == 0) begin
            i8.prod_valid = v; i8.prod = p; i8.clear = clr; i8.sum_ready = rdy;
        end else begin
            i32.prod_valid = v; i32.prod = p; i32.clear = clr; i32.sum_ready = rdy;
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_valid = 0; m_ovf = 0; m_total = 0; m_cnt = 0; m_sum = 0;
    endtask

    // One clock: drive, check ready, advance the model, check registered outputs after the edge
    task automatic cycle(input string tag, input logic v, input logic [7:0] p, input logic clr, input logic rdy);
        logic pr, sv, ov;
        logic [31:0] sm;
        drive(v, p, clr, rdy);
        read_out(pr, sm, sv, ov);
        chk({tag, "_prod_ready"}, 32'(pr), 32'(!m_hold));
        if (m_hold) begin
            if (rdy) begin m_hold = 0; m_valid = 0; m_ovf = 0; end
        end else if (clr) begin
            m_total = 0; m_cnt = 0; m_ovf = 0;
        end else if (v) begin
            m_total += int'(p);
            m_cnt++;
            if (m_total > ACC_MAX) m_ovf = 1;
            if (m_cnt == nterms) begin
                m_sum = group_result(m_total);
                m_valid = 1; m_hold = 1; m_total = 0; m_cnt = 0;
            end
        end
        @(posedge clk); #1;
        read_out(pr, sm, sv, ov);
        chk({tag, "_sum_valid"}, 32'(sv), 32'(m_valid));
        chk({tag, "_ovf"}, 32'(ov), 32'(m_ovf));
        if (m_valid) chk({tag, "_sum"}, sm, 32'(m_sum));
    endtask

    // Async reset: outputs must drop before any clock edge, ready must be up after release
    task automatic do_reset(input string tag);
        logic pr, sv, ov;
        logic [31:0] sm;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        read_out(pr, sm, sv, ov);
        chk({tag, "_rst_sum"}, sm, 32'd0);
        chk({tag, "_rst_sum_valid"}, 32'(sv), 32'd0);
        chk({tag, "_rst_ovf"}, 32'(ov), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        read_out(pr, sm, sv, ov);
        chk({tag, "_post_rst_ready"}, 32'(pr), 32'd1);
    endtask

    task automatic select(input int s);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        sel = s;
        nterms = (s == 0) ? 8 : 32;
        do_reset("sel");
    endtask

    logic        t_pr, t_sv, t_ov;
    logic [31:0] t_sm;

    initial begin
        i8.prod_valid = 0;  i8.prod = 0;  i8.clear = 0;  i8.sum_ready = 0;
        i32.prod_valid = 0; i32.prod = 0; i32.clear = 0; i32.sum_ready = 0;
        #12;
        rst = 1'b0;
        sel = 0;
        do_reset("init");

        // Eight full-scale products, consumer always ready
        for (int i = 0; i < 8; i++) cycle("r029", 1'b1, 8'd225, 1'b0, 1'b1);
        read_out(t_pr, t_sm, t_sv, t_ov);
        chk("r029_sum_const", t_sm, 32'd1800);
        cycle("r029_drain", 1'b0, 8'd0, 1'b0, 1'b1);

        // Result held while consumer stalls; prod ignored in HOLD
        for (int i = 0; i < 8; i++) cycle("r030", 1'b1, 8'd10, 1'b0, 1'b0);
        chk("r030_sum_const", 32'(i8.sum), 32'd80);
        for (int i = 0; i < 5; i++) cycle("r030_hold", 1'b1, 8'd10, 1'b1, 1'b0);
        chk("r030_sum_stable", 32'(i8.sum), 32'd80);
        cycle("r030_release", 1'b1, 8'd10, 1'b0, 1'b1);
        cycle("r030_next", 1'b1, 8'd10, 1'b0, 1'b1);
        do_reset("r030_end");

        // Abort mid-group discards the concurrent product
        for (int i = 0; i < 3; i++) cycle("r031", 1'b1, 8'd50, 1'b0, 1'b1);
        cycle("r031_clear", 1'b1, 8'd99, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle("r031_ones", 1'b1, 8'd1, 1'b0, 1'b0);
        chk("r031_sum_const", 32'(i8.sum), 32'd8);
        cycle("r031_drain", 1'b0, 8'd0, 1'b0, 1'b1);

        // Gapped valid: only valid beats count
        for (int i = 0; i < 16; i++) cycle("r034", (i % 2) == 0, 8'd3, 1'b0, 1'b0);
        chk("r034_sum_const", 32'(i8.sum), 32'd24);
        cycle("r034_drain", 1'b0, 8'd0, 1'b0, 1'b1);

        // Reset mid-group and again while holding
        for (int i = 0; i < 5; i++) cycle("r033a", 1'b1, 8'd7, 1'b0, 1'b1);
        do_reset("r033_mid");
        for (int i = 0; i < 8; i++) cycle("r033b", 1'b1, 8'd9, 1'b0, 1'b0);
        do_reset("r033_hold");
        for (int i = 0; i < 8; i++) cycle("r033c", 1'b1, 8'd11, 1'b0, 1'b0);
        chk("r033_sum_const", 32'(i8.sum), 32'd88);
        cycle("r033_drain", 1'b0, 8'd0, 1'b0, 1'b1);

        // Random traffic on the 8-term block
        for (int i = 0; i < 400; i++)
            cycle("rand8", ($urandom % 4) != 0,
                  8'($urandom_range(0, 15) * $urandom_range(0, 15)),
                  ($urandom % 16) == 0, ($urandom % 3) != 0);

        // 32-term block: overflow behaviour
        select(1);
        for (int i = 0; i < 32; i++) cycle("r032", 1'b1, 8'd225, 1'b0, 1'b0);
        chk("r032_sum_const", 32'(i32.sum), SAT ? 32'd4095 : 32'd3104);
        chk("r032_ovf_const", 32'(i32.ovf), 32'd1);
        cycle("r032_release", 1'b0, 8'd0, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            cycle("rand32", ($urandom % 5) != 0,
                  8'($urandom_range(0, 15) * $urandom_range(0, 15)),
                  ($urandom % 40) == 0, ($urandom % 2) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter NTERMS, default 8, number of products summed per result (legal range 2..255).
REQ-002 SHALL have parameter ACC_W, default 12, accumulator and result width in bits (legal range 9..16).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, synchronous abort: drop the partial sum and term count.
REQ-006 SHALL have port prod, input, 8, unsigned 4x4 product from the upstream Wallace multiplier.
REQ-007 SHALL have port prod_valid, input, 1, prod is valid this cycle.
REQ-008 SHALL have port prod_ready, output, 1, block accepts prod this cycle.
REQ-009 SHALL have port sum, output, ACC_W, completed accumulation result.
REQ-010 SHALL have port sum_valid, output, 1, sum holds a completed result.
REQ-011 SHALL have port sum_ready, input, 1, downstream consumes sum.
REQ-012 SHALL have port ovf, output, 1, sticky flag: overflow occurred in the current or held result.

Function
REQ-013 SHALL implement FSM states ACCUM and HOLD.
REQ-014 SHALL drive prod_ready = 1 in ACCUM and 0 in HOLD, with no combinational path from prod_valid.
REQ-015 SHALL define accept = prod_valid & prod_ready & ~clear; on accept, acc <= acc + zero-extended prod and cnt <= cnt + 1.
REQ-016 SHALL treat cnt == NTERMS-1 at accept as the final term: sum <= acc + prod, sum_valid <= 1, acc <= 0, cnt <= 0, go to HOLD, all in the same edge.
REQ-017 SHALL register sum, so sum_valid rises one cycle after the final accept (latency 1).
REQ-018 SHALL hold sum, sum_valid and ovf stable in HOLD until sum_ready = 1.
REQ-019 SHALL, in HOLD with sum_ready = 1, deassert sum_valid, clear ovf and return to ACCUM; the next prod is accepted in the following cycle.
REQ-020 SHALL set ovf when the ACC_W-bit addition carries out of the MSB.
REQ-021 SHALL, when clear = 1 in ACCUM, zero acc, cnt and ovf and discard any concurrent prod; clear takes priority over accept.
REQ-022 SHALL ignore clear in HOLD, so a held result is never destroyed.
REQ-023 SHALL keep acc and cnt unchanged in cycles with prod_valid = 0.

Reset
REQ-024 SHALL, on rst high, immediately (asynchronously) set state = ACCUM, acc = 0, cnt = 0, sum = 0, sum_valid = 0, ovf = 0; prod_ready = 1 after release.
REQ-025 SHALL abandon any partial sum or held result when rst is asserted mid-operation; no stale sum_valid after release.

Configuration
REQ-026 SHALL use the macro MAC_ACCUMULATOR_SATURATE_EN.
REQ-027 SHALL, with the macro defined, clamp acc and sum to 2^ACC_W-1 on overflow and keep them there for the remaining terms of that result; ovf sets.
REQ-028 SHALL, without the macro, wrap acc and sum modulo 2^ACC_W; ovf sets identically.

Verification
REQ-029 SHALL cover: rst, then 8 accepts of prod=225 with sum_ready=1 -> sum=1800, sum_valid one cycle after the 8th accept, ovf=0.
REQ-030 SHALL cover: NTERMS=8, prod=10 on 8 cycles, sum_ready held 0 for 5 cycles -> sum=80 stable, prod_ready=0 throughout HOLD, and the next prod is accepted the cycle after sum_ready=1.
REQ-031 SHALL cover: 3 accepts of prod=50, then clear together with prod_valid and prod=99 -> prod=99 is discarded; the next 8 prod=1 give sum=8.
REQ-032 SHALL cover: NTERMS=32, 32 accepts of prod=225 -> sum=4095 and ovf=1 with the macro; sum=7200 mod 4096=3104 and ovf=1 without it.
REQ-033 SHALL cover: rst asserted after 5 accepts and again while in HOLD -> all outputs 0 immediately; prod_ready=1 after release; the next full group gives the correct sum.
REQ-034 SHALL cover: prod_valid toggling 1/0 every cycle with prod=3 -> only valid cycles count; sum=24 after 8 valid beats.
